// File: rtl/vga_timing_prog.sv
// vga_timing_prog: raster timing generator whose timing is set at runtime.
//
// Timing fields and sync polarity are written into a shadow set over a simple
// config port. The shadow set is copied to the active set only on the frame
// wrap cycle that follows a COMMIT write, so a frame is never drawn with a
// mix of old and new timing.
//
// Ports:
//   dot_clk      pixel clock, rising edge
//   reset        asynchronous, active-high
//   cfg_we       config write strobe
//   cfg_addr     0..7 timing fields, 8 POL, 9 RASTER, 15 COMMIT
//   cfg_wdata    write data (LSBs used for narrower fields)
//   cfg_pending  COMMIT written, not yet applied
//   column/line  raster position
//   visible      inside the active picture
//   hsync/vsync  syncs, polarity from active POL
//   line_start   column==0
//   frame_start  column==0 and line==0
//   raster_irq   column==0 and line==RASTER
module vga_timing_prog #(
    parameter int         COL_WIDTH     = 11,
    parameter int         ROW_WIDTH     = 10,
    parameter int         DEF_H_VISIBLE = 640,
    parameter int         DEF_H_FRONT   = 16,
    parameter int         DEF_H_SYNC    = 64,
    parameter int         DEF_H_BACK    = 120,
    parameter int         DEF_V_VISIBLE = 480,
    parameter int         DEF_V_FRONT   = 1,
    parameter int         DEF_V_SYNC    = 3,
    parameter int         DEF_V_BACK    = 16,
    parameter logic [1:0] DEF_POL       = 2'b00,
    parameter int         DEF_RASTER    = 0
) (
    input  logic                 dot_clk,
    input  logic                 reset,
    input  logic                 cfg_we,
    input  logic [3:0]           cfg_addr,
    input  logic [((COL_WIDTH > ROW_WIDTH) ? COL_WIDTH : ROW_WIDTH)-1:0] cfg_wdata,
    output logic                 cfg_pending,
    output logic [COL_WIDTH-1:0] column,
    output logic [ROW_WIDTH-1:0] line,
    output logic                 visible,
    output logic                 hsync,
    output logic                 vsync,
    output logic                 line_start,
    output logic                 frame_start,
    output logic                 raster_irq
);
    localparam int CW = COL_WIDTH;
    localparam int RW = ROW_WIDTH;

    typedef struct packed {
        logic [CW-1:0] hvis;
        logic [CW-1:0] hfp;
        logic [CW-1:0] hsw;
        logic [CW-1:0] hbp;
        logic [RW-1:0] vvis;
        logic [RW-1:0] vfp;
        logic [RW-1:0] vsw;
        logic [RW-1:0] vbp;
        logic [1:0]    pol;
        logic [RW-1:0] raster;
    } tset_t;

    localparam tset_t DEF_SET = '{
        hvis:   CW'(DEF_H_VISIBLE),
        hfp:    CW'(DEF_H_FRONT),
        hsw:    CW'(DEF_H_SYNC),
        hbp:    CW'(DEF_H_BACK),
        vvis:   RW'(DEF_V_VISIBLE),
        vfp:    RW'(DEF_V_FRONT),
        vsw:    RW'(DEF_V_SYNC),
        vbp:    RW'(DEF_V_BACK),
        pol:    DEF_POL,
        raster: RW'(DEF_RASTER)
    };

    tset_t act, shd, nxt_set;

    // ---------------- shadow register writes ----------------
    logic [CW-1:0] fld_h;
    logic [RW-1:0] fld_v;
    logic          commit_wr;

    // Timing fields never hold 0: a zero write is stored as 1.
    assign fld_h     = (cfg_wdata[CW-1:0] == '0) ? CW'(1) : cfg_wdata[CW-1:0];
    assign fld_v     = (cfg_wdata[RW-1:0] == '0) ? RW'(1) : cfg_wdata[RW-1:0];
    assign commit_wr = cfg_we && (cfg_addr == 4'hF);

    always_ff @(posedge dot_clk or posedge reset) begin
        if (reset) begin
            shd <= DEF_SET;
        end else if (cfg_we) begin
            case (cfg_addr)
                4'd0: shd.hvis   <= fld_h;
                4'd1: shd.hfp    <= fld_h;
                4'd2: shd.hsw    <= fld_h;
                4'd3: shd.hbp    <= fld_h;
                4'd4: shd.vvis   <= fld_v;
                4'd5: shd.vfp    <= fld_v;
                4'd6: shd.vsw    <= fld_v;
                4'd7: shd.vbp    <= fld_v;
                4'd8: shd.pol    <= cfg_wdata[1:0];
                4'd9: shd.raster <= cfg_wdata[RW-1:0];
                default: ;
            endcase
        end
    end

    // ---------------- counters and next-cycle outputs ----------------
    logic [CW+1:0] htot, hs_lo, hs_hi;
    logic [RW+1:0] vtot, vs_lo, vs_hi;
    logic          col_last, line_last, commit_now;
    logic [CW-1:0] nxt_col;
    logic [RW-1:0] nxt_line;

    assign htot = {2'b00, act.hvis} + {2'b00, act.hfp} + {2'b00, act.hsw} + {2'b00, act.hbp};
    assign vtot = {2'b00, act.vvis} + {2'b00, act.vfp} + {2'b00, act.vsw} + {2'b00, act.vbp};

    assign col_last   = ({2'b00, column} == htot - (CW+2)'(1));
    assign line_last  = ({2'b00, line} == vtot - (RW+2)'(1));
    assign commit_now = col_last && line_last && cfg_pending;

    // Outputs are computed from the next position and the set that will be
    // active then, so a committed mode is already in force at column 0/line 0.
    assign nxt_set  = commit_now ? shd : act;
    assign nxt_col  = col_last ? '0 : column + CW'(1);
    assign nxt_line = col_last ? (line_last ? '0 : line + RW'(1)) : line;

    assign hs_lo = {2'b00, nxt_set.hvis} + {2'b00, nxt_set.hfp};
    assign hs_hi = hs_lo + {2'b00, nxt_set.hsw};
    assign vs_lo = {2'b00, nxt_set.vvis} + {2'b00, nxt_set.vfp};
    assign vs_hi = vs_lo + {2'b00, nxt_set.vsw};

    logic hs_on, vs_on, col0_n;
    assign hs_on  = ({2'b00, nxt_col} >= hs_lo) && ({2'b00, nxt_col} < hs_hi);
    assign vs_on  = ({2'b00, nxt_line} >= vs_lo) && ({2'b00, nxt_line} < vs_hi);
    assign col0_n = (nxt_col == '0);

    always_ff @(posedge dot_clk or posedge reset) begin
        if (reset) begin
            act         <= DEF_SET;
            cfg_pending <= 1'b0;
            column      <= '0;
            line        <= '0;
            visible     <= 1'b1;
            hsync       <= ~DEF_POL[0];
            vsync       <= ~DEF_POL[1];
            line_start  <= 1'b1;
            frame_start <= 1'b1;
            raster_irq  <= (DEF_RASTER == 0);
        end else begin
            act         <= nxt_set;
            // A COMMIT landing on the wrap cycle re-arms for the next wrap.
            cfg_pending <= commit_wr ? 1'b1 : (commit_now ? 1'b0 : cfg_pending);
            column      <= nxt_col;
            line        <= nxt_line;
            visible     <= (nxt_col < nxt_set.hvis) && (nxt_line < nxt_set.vvis);
            hsync       <= hs_on ? nxt_set.pol[0] : ~nxt_set.pol[0];
            vsync       <= vs_on ? nxt_set.pol[1] : ~nxt_set.pol[1];
            line_start  <= col0_n;
            frame_start <= col0_n && (nxt_line == '0);
            raster_irq  <= col0_n && (nxt_line == nxt_set.raster);
        end
    end
endmodule

// File: tb/tb_vga_timing_prog.sv
// Scoreboard bench for vga_timing_prog. The stimulus process predicts every
// cycle's outputs from a frame-position model (column = t mod Htotal,
// line = t div Htotal) and queues them; the monitor pops one entry per cycle
// and compares. Vertical defaults are shrunk (Vtotal 12) so a default frame
// costs ~10k cycles instead of 420k; horizontal defaults are kept as-is.
module tb_vga_timing_prog;
    localparam int TB_V_VIS  = 6;
    localparam int TB_V_BACK = 2;

    logic        dot_clk = 1'b0;
    logic        reset   = 1'b1;
    logic        cfg_we  = 1'b0;
    logic [3:0]  cfg_addr = '0;
    logic [10:0] cfg_wdata = '0;
    logic        cfg_pending, visible, hsync, vsync, line_start, frame_start, raster_irq;
    logic [10:0] column;
    logic [9:0]  line;

    vga_timing_prog #(.DEF_V_VISIBLE(TB_V_VIS), .DEF_V_BACK(TB_V_BACK)) dut (
        .dot_clk(dot_clk), .reset(reset), .cfg_we(cfg_we), .cfg_addr(cfg_addr),
        .cfg_wdata(cfg_wdata), .cfg_pending(cfg_pending), .column(column), .line(line),
        .visible(visible), .hsync(hsync), .vsync(vsync), .line_start(line_start),
        .frame_start(frame_start), .raster_irq(raster_irq)
    );

    always #5 dot_clk = ~dot_clk;

    typedef struct packed {
        logic [10:0] col;
        logic [9:0]  ln;
        logic vis, hs, vs, ls, fs, ri, pend;
    } obs_t;

    obs_t sb[$];
    int   total = 0;
    int   bad   = 0;

    // ---------------- reference model ----------------
    // index: 0 HVIS 1 HFP 2 HSYNC 3 HBP 4 VVIS 5 VFP 6 VSYNC 7 VBP 8 POL 9 RASTER
    int DEF_M[10] = '{640, 16, 64, 120, TB_V_VIS, 1, 3, TB_V_BACK, 0, 0};
    int act[10];
    int shd[10];
    bit pend;
    int t;   // cycle index within the current frame

    function automatic int htot(); return act[0] + act[1] + act[2] + act[3]; endfunction
    function automatic int vtot(); return act[4] + act[5] + act[6] + act[7]; endfunction
    function automatic int flen(); return htot() * vtot(); endfunction

    function automatic void model_reset();
        act  = DEF_M;
        shd  = DEF_M;
        pend = 1'b0;
        t    = 0;
    endfunction

    function automatic obs_t model_obs();
        obs_t o;
        int c, l, p;
        c = t % htot();
        l = t / htot();
        p = act[8];
        o.col  = 11'(c);
        o.ln   = 10'(l);
        o.vis  = (c < act[0]) && (l < act[4]);
        o.hs   = ((c >= act[0] + act[1]) && (c < act[0] + act[1] + act[2])) ? p[0] : !p[0];
        o.vs   = ((l >= act[4] + act[5]) && (l < act[4] + act[5] + act[6])) ? p[1] : !p[1];
        o.ls   = (c == 0);
        o.fs   = (t == 0);
        o.ri   = (c == 0) && (l == act[9]);
        o.pend = pend;
        return o;
    endfunction

    // Effect of one clock edge given the inputs presented during the cycle.
    function automatic void model_edge(input bit we, input int a, input int d);
        int v;
        if (t == flen() - 1) begin
            t = 0;
            if (pend) begin
                act  = shd;
                pend = 1'b0;
            end
        end else begin
            t++;
        end
        if (we) begin
            if (a == 15) pend = 1'b1;
            else if (a <= 3) begin v = d & 2047; shd[a] = (v == 0) ? 1 : v; end
            else if (a <= 7) begin v = d & 1023; shd[a] = (v == 0) ? 1 : v; end
            else if (a == 8) shd[a] = d & 3;
            else if (a == 9) shd[a] = d & 1023;
        end
    endfunction

    // ---------------- stimulus ----------------
    task automatic step(input bit rst_v, input bit we, input int a, input int d);
        @(posedge dot_clk);
        #1;
        reset     = rst_v;
        cfg_we    = we;
        cfg_addr  = 4'(a);
        cfg_wdata = 11'(d);
        if (rst_v) model_reset();
        sb.push_back(model_obs());
        if (!rst_v) model_edge(we, a, d);
    endtask

    // Idle cycle: occasionally a write to an unmapped address (10-14).
    task automatic idle();
        if ($urandom_range(0, 7) == 0) step(0, 1, $urandom_range(10, 14), $urandom_range(0, 2047));
        else                           step(0, 0, 0, 0);
    endtask

    // Leaves the next step() landing on the frame wrap cycle.
    task automatic run_to_wrap();
        while (t != flen() - 1) idle();
    endtask

    task automatic wr(input int a, input int d);
        step(0, 1, a, d);
    endtask

    // ---------------- monitor ----------------
    always @(negedge dot_clk) begin
        obs_t e, g;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            g = '{col: column, ln: line, vis: visible, hs: hsync, vs: vsync,
                  ls: line_start, fs: frame_start, ri: raster_irq, pend: cfg_pending};
            total++;
            if (g !== e) begin
                bad++;
                $display("FAIL outputs t=%0t got col=%0d ln=%0d vis=%b hs=%b vs=%b ls=%b fs=%b ri=%b pend=%b want col=%0d ln=%0d vis=%b hs=%b vs=%b ls=%b fs=%b ri=%b pend=%b",
                         $time, g.col, g.ln, g.vis, g.hs, g.vs, g.ls, g.fs, g.ri, g.pend,
                         e.col, e.ln, e.vis, e.hs, e.vs, e.ls, e.fs, e.ri, e.pend);
            end
        end
    end

    initial begin
        int line_sel;
        model_reset();

        // Reset state, then two full default frames.
        step(1, 0, 0, 0);
        step(1, 0, 0, 0);
        repeat (2 * flen()) idle();

        // Mid-frame reprogram to the small mode, COMMIT part way down the frame.
        line_sel = $urandom_range(3, 8);
        while (t < line_sel * htot()) idle();
        wr(0, 8); wr(1, 2); wr(2, 3); wr(3, 1);
        wr(4, 4); wr(5, 1); wr(6, 1); wr(7, 1);
        wr(15, $urandom_range(0, 2047));
        run_to_wrap();
        idle();
        repeat (3) begin run_to_wrap(); idle(); end

        // COMMIT on the wrap cycle itself: applied one frame later.
        wr(0, 9);
        run_to_wrap();
        wr(15, 0);
        run_to_wrap(); idle();
        run_to_wrap(); idle();

        // Active-high syncs, raster compare on line 5.
        wr(0, 8); wr(8, 3); wr(9, 5); wr(15, 0);
        repeat (3) begin run_to_wrap(); idle(); end

        // Zero writes behave as 1.
        wr(2, 0); wr(7, 0); wr(15, 0);
        repeat (3) begin run_to_wrap(); idle(); end

        // A few random small modes.
        repeat (3) begin
            for (int i = 0; i < 4; i++) wr(i, $urandom_range(1, 6));
            for (int i = 4; i < 8; i++) wr(i, $urandom_range(1, 3));
            wr(8, $urandom_range(0, 3));
            wr(9, $urandom_range(0, 3));
            wr(15, 0);
            repeat (2) begin run_to_wrap(); idle(); end
        end

        // Asynchronous reset mid-line with a commit pending.
        wr(0, 5); wr(15, 0);
        repeat (3) idle();
        step(1, 0, 0, 0);
        step(1, 0, 0, 0);
        repeat (1000) idle();

        repeat (2) @(posedge dot_clk);
        @(negedge dot_clk);
        #1;
        total++;
        if (sb.size() != 0) begin
            bad++;
            $display("FAIL drain left=%0d want=0", sb.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
